// File: rtl/aes_pkg.sv
// AES shared definitions for the decryption round tail.
// GF(2^8) helpers and FSM encoding.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns constants 09/0b/0d/0e.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] c);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h09:   r = x8 ^ a;
            8'h0b:   r = x8 ^ x2 ^ a;
            8'h0d:   r = x8 ^ x4 ^ a;
            8'h0e:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// InvMixColumns on one 32-bit column.
// Byte 0 of the column sits in bits [31:24].
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_b0, w_b1, w_b2, w_b3;

    assign w_b0 = i_col[31:24];
    assign w_b1 = i_col[23:16];
    assign w_b2 = i_col[15:8];
    assign w_b3 = i_col[7:0];

    // Circulant matrix rows {0e,0b,0d,09} rotated right per row.
    always_comb begin
        o_col[31:24] = gf_mul(w_b0, 8'h0e) ^ gf_mul(w_b1, 8'h0b)
                     ^ gf_mul(w_b2, 8'h0d) ^ gf_mul(w_b3, 8'h09);
        o_col[23:16] = gf_mul(w_b0, 8'h09) ^ gf_mul(w_b1, 8'h0e)
                     ^ gf_mul(w_b2, 8'h0b) ^ gf_mul(w_b3, 8'h0d);
        o_col[15:8]  = gf_mul(w_b0, 8'h0d) ^ gf_mul(w_b1, 8'h09)
                     ^ gf_mul(w_b2, 8'h0e) ^ gf_mul(w_b3, 8'h0b);
        o_col[7:0]   = gf_mul(w_b0, 8'h0b) ^ gf_mul(w_b1, 8'h0d)
                     ^ gf_mul(w_b2, 8'h09) ^ gf_mul(w_b3, 8'h0e);
    end

endmodule

// File: rtl/inv_round_tail.sv
// AES decryption round tail: AddRoundKey, then InvMixColumns
// one column per cycle unless the round is the last one.
module inv_round_tail
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [STATE_W-1:0] round_key,
    input  logic               last_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out
);

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;
    logic [1:0]         r_col;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_mixed;
    logic [31:0]        w_col_in;
    logic [31:0]        w_col_out;
    logic               w_accept;

    inv_mix_column u_imc (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    // Next state, handshake outputs; DONE can accept a new block.
    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_fsm_nxt = last_round ? DONE : MIX;
            end
            MIX: begin
                if (r_col == 2'd3)
                    w_fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid)
                        w_fsm_nxt = last_round ? DONE : MIX;
                    else
                        w_fsm_nxt = IDLE;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    assign w_accept  = in_valid & in_ready;
    assign state_out = r_state;

    // Select the active column and splice its mixed value back in.
    always_comb begin
        w_mixed = r_state;
        unique case (r_col)
            2'd0: w_col_in = r_state[127:96];
            2'd1: w_col_in = r_state[95:64];
            2'd2: w_col_in = r_state[63:32];
            default: w_col_in = r_state[31:0];
        endcase
        unique case (r_col)
            2'd0: w_mixed[127:96] = w_col_out;
            2'd1: w_mixed[95:64]  = w_col_out;
            2'd2: w_mixed[63:32]  = w_col_out;
            default: w_mixed[31:0] = w_col_out;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fsm <= IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    // State register: load on accept, one column per MIX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_col   <= 2'd0;
        end else if (w_accept) begin
            r_state <= state_in ^ round_key;
            r_col   <= 2'd0;
        end else if (r_fsm == MIX) begin
            r_state <= w_mixed;
            r_col   <= r_col + 2'd1;
        end
    end

endmodule

// File: tb/tb_inv_round_tail.sv
// Scoreboard bench for inv_round_tail: directed FIPS-197
// vectors, backpressure, async reset and random traffic.
module tb_inv_round_tail;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    logic [127:0] q[$];
    int n_chk  = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_pop  = 0;

    localparam logic [127:0] C1_S = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_R = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] FR_S = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] FR_K = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] FR_R = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] IM_S = {4{32'h8e4da1bc}};
    localparam logic [127:0] IM_R = {4{32'hdb135345}};

    inv_round_tail dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .round_key  (round_key),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-serial GF(2^8) multiply, independent of xtime chains.
    function automatic logic [7:0] gm(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] imc(input logic [31:0] c);
        logic [7:0] b [4];
        logic [7:0] m [4];
        logic [7:0] r [4];
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int i = 0; i < 4; i++) b[i] = c[31-8*i -: 8];
        for (int row = 0; row < 4; row++) begin
            r[row] = 8'h00;
            for (int j = 0; j < 4; j++)
                r[row] = r[row] ^ gm(b[j], m[(j - row + 4) % 4]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s,
                                           input logic [127:0] k,
                                           input logic l);
        logic [127:0] x;
        x = s ^ k;
        if (!l)
            for (int c = 0; c < 4; c++)
                x[127-32*c -: 32] = imc(x[127-32*c -: 32]);
        return x;
    endfunction

    // Monitor: a transfer happens at the next edge when both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", state_out, 128'hx);
            end else begin
                chk("scoreboard", state_out, q.pop_front());
                n_pop++;
            end
        end
    end

    // Drive a block and hold it until accepted; returns after edge.
    task automatic send(input logic [127:0] s, input logic [127:0] k,
                        input logic l, input logic [127:0] exp);
        int t;
        @(posedge clk); #1;
        state_in   = s;
        round_key  = k;
        last_round = l;
        in_valid   = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(exp);
                n_push++;
                break;
            end
            t++;
            if (t > 200) begin
                chk("accept_timeout", 128'(t), 128'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0)
            chk("drain_timeout", 128'(q.size()), 128'd0);
    endtask

    // Cycles (negedges) from acceptance until out_valid.
    task automatic latency(input string name, input int exp,
                           input logic chk_mix);
        int lat;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (chk_mix) chk({name, "_in_ready_mix"}, 128'(in_ready), 128'd0);
        end
        chk(name, 128'(lat), 128'(exp));
    endtask

    task automatic backpressure(input logic [127:0] s2,
                                input logic [127:0] k2,
                                input logic l2,
                                input logic [127:0] e2);
        int t;
        out_ready = 1'b0;
        send(FR_S, FR_K, 1'b0, FR_R);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid_rise", 128'(out_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {state_out[127:2], out_valid, in_ready},
                {FR_R[127:2], 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        out_ready  = 1'b1;
        state_in   = s2;
        round_key  = k2;
        last_round = l2;
        in_valid   = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_accept", 128'(in_ready), 128'd1);
        q.push_back(e2);
        n_push++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_out_valid", 128'(out_valid), 128'(l2));
        wait_drain();
    endtask

    initial begin
        logic done;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        state_in   = '0;
        round_key  = '0;
        last_round = 1'b0;
        out_ready  = 1'b1;
        #22;
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_state_out", state_out, 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        send(C1_S, C1_K, 1'b1, C1_R);
        latency("lat_last", 1, 1'b0);
        wait_drain();

        send(FR_S, FR_K, 1'b0, FR_R);
        latency("lat_full", 5, 1'b1);
        wait_drain();

        send(IM_S, 128'd0, 1'b0, IM_R);
        wait_drain();

        backpressure(IM_S, 128'd0, 1'b0, IM_R);
        backpressure(C1_S, C1_K, 1'b1, C1_R);

        send(FR_S, FR_K, 1'b0, FR_R);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 128'(out_valid), 128'd0);
        chk("async_rst_state_out", state_out, 128'd0);
        chk("async_rst_in_ready", 128'(in_ready), 128'd1);
        void'(q.pop_back());
        n_push--;
        @(negedge clk);
        rst_n = 1'b1;
        send(FR_S, FR_K, 1'b0, FR_R);
        wait_drain();

        done = 1'b0;
        fork
            begin
                logic [127:0] s, k;
                logic l;
                for (int n = 0; n < 200; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    s = {$urandom, $urandom, $urandom, $urandom};
                    k = {$urandom, $urandom, $urandom, $urandom};
                    l = 1'($urandom_range(0, 1));
                    send(s, k, l, model(s, k, l));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
        chk("block_count", 128'(n_pop), 128'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
